// File: rtl/timer_pkg.sv
// Shared constants and helpers for the sound-chip timer family (var_timer, fixed_timer).
// The period-to-terminal rule lives here so every timer wraps the same way.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 3;

  // Terminal count for a divisor: period-1 taken modulo 2**width, so a
  // divisor of 0 becomes all-ones and divides by 2**width.
  function automatic logic [31:0] period_to_term(input logic [31:0] period,
                                                 input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (period - 32'd1) & mask;
  endfunction

  // True when a counter value has reached or passed its terminal count.
  function automatic logic at_terminal(input logic [31:0] count,
                                       input logic [31:0] term);
    return count >= term;
  endfunction

endpackage

// File: rtl/var_timer.sv
// Programmable clock-enable divider: one-cycle registered pulse on clkOut
// every `period` clk edges; the divisor may be retuned while running.
module var_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period,
  output logic             clkOut
);

  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] term;
  logic             wrap;

  assign term = WIDTH'(period_to_term(32'(period), WIDTH));
  // Compare with >= so a live drop of the divisor wraps at once instead of
  // counting on up to the all-ones overflow.
  assign wrap = at_terminal(32'(i), 32'(term));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i      <= '0;
      clkOut <= 1'b0;
    end else if (wrap) begin
      i      <= '0;
      clkOut <= 1'b1;
    end else begin
      i      <= i + WIDTH'(1);
      clkOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_var_timer.sv
// Randomised self-checking bench for var_timer against an edge-counting model.
module tb_var_timer;

  logic       clk;
  logic       rst_n;
  logic [2:0] period;
  logic       clkOut;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles elapsed since the last pulse, and the pulse flag.
  int m_i;
  bit m_out;

  var_timer #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .period(period),
    .clkOut(clkOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; the divisor seen is the one held across the edge.
  task automatic tick();
    int div;
    div = (period == 3'd0) ? 8 : int'(period);
    @(posedge clk);
    if (m_i + 1 >= div) begin
      m_i   = 0;
      m_out = 1'b1;
    end else begin
      m_i   = m_i + 1;
      m_out = 1'b0;
    end
    #1;
  endtask

  // Pulse reset between edges and clear the model.
  task automatic do_reset();
    rst_n = 1'b0;
    m_i   = 0;
    m_out = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    period = 3'd5;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut.i !== 3'd0 || clkOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: i=%0d clkOut=%0b, required i=0 clkOut=0", dut.i, clkOut);
    end
    m_i = 0;
    m_out = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (clkOut !== 1'b0 || int'(dut.i) != m_i) begin
        errors++;
        $display("FAIL reset_release edge %0d: i=%0d clkOut=%0b, required i=%0d clkOut=0",
                 k, dut.i, clkOut, m_i);
      end
    end
  endtask

  task automatic test_basic_divide();
    period = 3'd5;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (int'(dut.i) != m_i || clkOut !== m_out || clkOut !== (k % 5 == 0)) begin
        errors++;
        $display("FAIL basic_div5 edge %0d: i=%0d clkOut=%0b, required i=%0d clkOut=%0b",
                 k, dut.i, clkOut, m_i, m_out);
      end
    end
  endtask

  task automatic test_small_periods();
    period = 3'd1;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dut.i !== 3'd0 || clkOut !== 1'b1) begin
        errors++;
        $display("FAIL period1 edge %0d: i=%0d clkOut=%0b, required i=0 clkOut=1", k, dut.i, clkOut);
      end
    end
    period = 3'd2;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (clkOut !== (k % 2 == 0) || int'(dut.i) != m_i) begin
        errors++;
        $display("FAIL period2 edge %0d: i=%0d clkOut=%0b, required i=%0d clkOut=%0b",
                 k, dut.i, clkOut, m_i, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_period_zero();
    period = 3'd0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (int'(dut.i) != (k % 8) || clkOut !== (k % 8 == 0) || clkOut !== m_out) begin
        errors++;
        $display("FAIL period0 edge %0d: i=%0d clkOut=%0b, required i=%0d clkOut=%0b",
                 k, dut.i, clkOut, k % 8, (k % 8 == 0));
      end
    end
  endtask

  task automatic test_live_change();
    period = 3'd5;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    period = 3'd3;
    tick();
    checks++;
    if (dut.i !== 3'd0 || clkOut !== 1'b1) begin
      errors++;
      $display("FAIL live_change wrap: i=%0d clkOut=%0b, required i=0 clkOut=1", dut.i, clkOut);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (clkOut !== (k % 3 == 0) || int'(dut.i) != (k % 3)) begin
        errors++;
        $display("FAIL live_change div3 edge %0d: i=%0d clkOut=%0b, required i=%0d clkOut=%0b",
                 k, dut.i, clkOut, k % 3, (k % 3 == 0));
      end
    end
  endtask

  task automatic test_reset_on_terminal();
    period = 3'd5;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    m_i = 0;
    m_out = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut.i !== 3'd0 || clkOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_on_terminal: i=%0d clkOut=%0b, required i=0 clkOut=0", dut.i, clkOut);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    period = 3'($urandom_range(0, 7));
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) period = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        checks++;
        if (dut.i !== 3'd0 || clkOut !== 1'b0) begin
          errors++;
          $display("FAIL random_reset step %0d: i=%0d clkOut=%0b, required i=0 clkOut=0",
                   k, dut.i, clkOut);
        end
      end
      tick();
      checks++;
      if (int'(dut.i) != m_i || clkOut !== m_out) begin
        errors++;
        $display("FAIL random step %0d period=%0d: i=%0d clkOut=%0b, required i=%0d clkOut=%0b",
                 k, period, dut.i, clkOut, m_i, m_out);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    period = 3'd5;
    m_i    = 0;
    m_out  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut.i !== 3'd0 || clkOut !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset: i=%0d clkOut=%0b, required i=0 clkOut=0", dut.i, clkOut);
    end
    rst_n = 1'b1;
    test_reset();
    test_basic_divide();
    test_small_periods();
    test_period_zero();
    test_live_change();
    test_reset_on_terminal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
